// File: rtl/sd_cmd_resp_rx.sv
// sd_cmd_resp_rx: SD command-line response receiver (short 48-bit / long 136-bit).
// Waits a bounded number of SD clock strobes for the start bit after being armed.
// Then captures the frame MSB-first and reports index, payload, CRC7, framing and timeout status.
// Build option: define SD_RESP_CRC_EN to include the serial CRC7 checker. Without it,
// crc_err is tied low and crc_skip is ignored.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | not busy; results from the last receive are held
// S_WAIT_START | armed; counting idle strobes while waiting for the start bit
// S_RECV       | shifting frame bits; bit_cnt holds the frame position being received
// S_CHECK      | one-cycle done pulse after the end bit or timeout
module sd_cmd_resp_rx #(
    parameter int NCR_MAX    = 64,
    parameter int SHORT_BITS = 48,
    parameter int LONG_BITS  = 136
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 cmd_in,
    input  logic                 arm,
    input  logic                 resp_long,
    input  logic                 crc_skip,
    output logic                 busy,
    output logic                 done,
    output logic [5:0]           resp_index,
    output logic [LONG_BITS-9:0] resp_payload,
    output logic                 crc_err,
    output logic                 frame_err,
    output logic                 timeout_err
);

    localparam int TW = $clog2(NCR_MAX + 1);
    localparam int BW = $clog2(LONG_BITS);
    localparam int PW = LONG_BITS - 8;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_RECV       = 2'd2,
        S_CHECK      = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic                   mode_long;
    logic [TW-1:0]          to_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [LONG_BITS-1:0]   shreg;
    logic [LONG_BITS-1:0]   frame_full;
    logic                   arm_ok, idle_strobe, to_hit, start_seen, recv_strobe, end_strobe;

    // The end-bit strobe sees the complete frame with cmd_in as bit 0. This lets the results
    // be registered on that edge so they are already valid during the done cycle.
    assign frame_full  = {shreg[LONG_BITS-2:0], cmd_in};

    // A new receive may be accepted whenever the block is not busy, including the done cycle.
    assign arm_ok      = arm && ((state == S_IDLE) || (state == S_CHECK));
    assign idle_strobe = (state == S_WAIT_START) && sample_en && cmd_in;
    assign to_hit      = idle_strobe && (to_cnt == TW'(NCR_MAX - 1));
    assign start_seen  = (state == S_WAIT_START) && sample_en && !cmd_in;
    assign recv_strobe = (state == S_RECV) && sample_en;
    assign end_strobe  = recv_strobe && (bit_cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (arm_ok) state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                if (start_seen)  state_nxt = S_RECV;
                else if (to_hit) state_nxt = S_CHECK;
            end
            S_RECV:       if (end_strobe) state_nxt = S_CHECK;
            S_CHECK:      state_nxt = arm_ok ? S_WAIT_START : S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_WAIT_START) || (state == S_RECV);
        done = (state == S_CHECK);
    end

    // Mode latch, timeout counter, shift register and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_long    <= 1'b0;
            to_cnt       <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            resp_index   <= '0;
            resp_payload <= '0;
            frame_err    <= 1'b0;
            timeout_err  <= 1'b0;
        end else if (arm_ok) begin
            mode_long   <= resp_long;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (idle_strobe) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_hit) timeout_err <= 1'b1;
            end
            if (start_seen) begin
                shreg   <= frame_full;
                bit_cnt <= mode_long ? BW'(LONG_BITS - 2) : BW'(SHORT_BITS - 2);
            end
            if (recv_strobe) begin
                shreg   <= frame_full;
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (end_strobe) begin
                resp_index <= frame_full[SHORT_BITS-3 -: 6];
                if (mode_long) begin
                    resp_payload <= frame_full[PW-1:0];
                    frame_err    <= frame_full[LONG_BITS-2] || !frame_full[0];
                end else begin
                    resp_payload <= {{(PW-32){1'b0}}, frame_full[SHORT_BITS-9 -: 32]};
                    frame_err    <= frame_full[SHORT_BITS-2] || !frame_full[0];
                end
            end
        end
    end

`ifdef SD_RESP_CRC_EN
    logic [6:0]    crc;
    logic          mode_skip;
    logic [BW-1:0] cur_pos, crc_hi;
    logic          crc_take;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Frame position of the bit on this strobe.
    // Long frames skip their first 8 bits, so only the CID/CSD body is covered.
    assign cur_pos  = (state == S_WAIT_START) ?
                      (mode_long ? BW'(LONG_BITS - 1) : BW'(SHORT_BITS - 1)) : bit_cnt;
    assign crc_hi   = mode_long ? BW'(LONG_BITS - 9) : BW'(SHORT_BITS - 1);
    assign crc_take = (start_seen || recv_strobe) && (cur_pos >= BW'(8)) && (cur_pos <= crc_hi);

    // Serial CRC7 accumulation and compare against received bits [7:1]
    always_ff @(posedge clk) begin
        if (reset) begin
            crc       <= '0;
            mode_skip <= 1'b0;
            crc_err   <= 1'b0;
        end else if (arm_ok) begin
            crc       <= '0;
            mode_skip <= crc_skip;
            crc_err   <= 1'b0;
        end else begin
            if (crc_take)   crc     <= crc7_step(crc, cmd_in);
            if (end_strobe) crc_err <= !mode_skip && (crc != frame_full[7:1]);
        end
    end

    logic unused_ok;
    assign unused_ok = shreg[LONG_BITS-1];
`else
    assign crc_err = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, crc_skip, shreg[LONG_BITS-1]};
`endif

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed plus randomized bench for sd_cmd_resp_rx with a frame-level reference model.
module tb_sd_cmd_resp_rx;
    localparam int NCR = 64;
    localparam int PW  = 128;

    logic clk = 1'b0;
    logic reset, sample_en, cmd_in, arm, resp_long, crc_skip;
    logic busy, done, crc_err, frame_err, timeout_err;
    logic [5:0]    resp_index;
    logic [PW-1:0] resp_payload;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    sd_cmd_resp_rx dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .cmd_in(cmd_in), .arm(arm),
        .resp_long(resp_long), .crc_skip(crc_skip), .busy(busy), .done(done),
        .resp_index(resp_index), .resp_payload(resp_payload), .crc_err(crc_err),
        .frame_err(frame_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of (message * x^7) divided by x^7+x^3+1
    function automatic logic [6:0] crc7_div(input logic [135:0] f, input int hi, input int lo);
        logic [142:0] r;
        int n;
        r = '0;
        n = hi - lo + 1;
        for (int i = 0; i < n; i++) r[i+7] = f[lo+i];
        for (int b = n + 6; b >= 7; b--) if (r[b]) r[b -: 8] = r[b -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic model(input logic [135:0] f, input logic lng, input logic skp,
                         output logic [5:0] idx, output logic [PW-1:0] pl,
                         output logic ce, output logic fe);
        int len;
        len = lng ? 136 : 48;
        idx = f[45:40];
        pl  = lng ? f[127:0] : {96'b0, f[39:8]};
        fe  = (f[len-2] != 1'b0) || (f[0] != 1'b1);
`ifdef SD_RESP_CRC_EN
        ce  = !skp && (crc7_div(f, lng ? 127 : 47, 8) != f[7:1]);
`else
        ce  = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input int gap);
        sample_en = 1'b1;
        cmd_in    = b;
        tick();
        sample_en = 1'b0;
        cmd_in    = 1'b1;
        arm       = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic do_arm(input logic lng, input logic skp, input logic with_strobe);
        arm       = 1'b1;
        resp_long = lng;
        crc_skip  = skp;
        if (with_strobe) begin
            sample_en = 1'b1;
            cmd_in    = 1'b0;
        end
        tick();
        arm       = 1'b0;
        sample_en = 1'b0;
        cmd_in    = 1'b1;
        resp_long = ~lng;
        crc_skip  = ~skp;
        chk1("busy_after_arm", busy, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [135:0] f, input logic lng,
                             input logic skp, input int gap, input int idle_n,
                             input logic arm_strobe, input logic rogue);
        int len, dc0;
        logic [5:0] e_idx;
        logic [PW-1:0] e_pl;
        logic e_ce, e_fe;
        len = lng ? 136 : 48;
        model(f, lng, skp, e_idx, e_pl, e_ce, e_fe);
        do_arm(lng, skp, arm_strobe);
        dc0 = done_cnt;
        repeat (idle_n) strobe(1'b1, gap);
        for (int i = len - 1; i > 0; i--) begin
            if (rogue && i == len - 10) begin
                arm       = 1'b1;
                resp_long = ~lng;
            end
            strobe(f[i], gap);
        end
        sample_en = 1'b1;
        cmd_in    = f[0];
        tick();
        sample_en = 1'b0;
        cmd_in    = 1'b1;
        chk($sformatf("%s_no_early_done", tag), PW'(done_cnt), PW'(dc0));
        chk1($sformatf("%s_done", tag), done, 1'b1);
        chk1($sformatf("%s_busy_low", tag), busy, 1'b0);
        chk($sformatf("%s_index", tag), PW'(resp_index), PW'(e_idx));
        chk($sformatf("%s_payload", tag), resp_payload, e_pl);
        chk1($sformatf("%s_crc_err", tag), crc_err, e_ce);
        chk1($sformatf("%s_frame_err", tag), frame_err, e_fe);
        chk1($sformatf("%s_timeout_err", tag), timeout_err, 1'b0);
        tick();
        chk1($sformatf("%s_done_one_cycle", tag), done, 1'b0);
        chk($sformatf("%s_done_count", tag), PW'(done_cnt), PW'(dc0 + 1));
        chk($sformatf("%s_payload_hold", tag), resp_payload, e_pl);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk({tag, "_index"}, PW'(resp_index), '0);
        chk({tag, "_payload"}, resp_payload, '0);
        chk1({tag, "_crc_err"}, crc_err, 1'b0);
        chk1({tag, "_frame_err"}, frame_err, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        logic [135:0] f, r1;
        int dc0;
        reset = 1'b1; sample_en = 1'b0; cmd_in = 1'b1; arm = 1'b0;
        resp_long = 1'b0; crc_skip = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_reset_vals("reset");

        r1 = {88'b0, 1'b0, 1'b0, 6'd55, 32'h0, 7'h78, 1'b1};
        run_frame("r1_cmd55", r1, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0);

        f = {88'b0, 1'b0, 1'b0, 6'h3F, 32'h00000001, 7'h7F, 1'b1};
        run_frame("r3_skip", f, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0);

        f = {1'b0, 1'b0, 6'h3F, 120'h7E4456BFAFE53C7AB12900000ECD, 7'h59, 1'b1};
        run_frame("r2_long", f, 1'b1, 1'b0, 2, 5, 1'b0, 1'b0);

        f = {88'b0, 1'b0, 1'b0, 6'd3, 16'hF792, 16'h0000, 7'h16, 1'b1};
        run_frame("r6_badcrc", f, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0);
        chk("r6_rca", PW'(resp_payload[31:16]), PW'(16'hF792));

        f = {88'b0, 1'b0, 1'b0, 6'd3, 16'hF792, 16'h0000, 7'h17, 1'b0};
        run_frame("r6_endbit", f, 1'b0, 1'b0, 2, 2, 1'b0, 1'b1);

        // Timeout: CMD line stays high after arm
        do_arm(1'b0, 1'b0, 1'b0);
        dc0 = done_cnt;
        repeat (NCR - 1) strobe(1'b1, 2);
        chk("to_no_early_done", PW'(done_cnt), PW'(dc0));
        chk1("to_busy_before", busy, 1'b1);
        sample_en = 1'b1; cmd_in = 1'b1;
        tick();
        sample_en = 1'b0;
        chk1("to_done", done, 1'b1);
        chk1("to_timeout_err", timeout_err, 1'b1);
        chk1("to_busy_low", busy, 1'b0);
        tick();
        chk1("to_done_one_cycle", done, 1'b0);

        // Reset on the 20th strobe of a short receive
        do_arm(1'b0, 1'b0, 1'b0);
        dc0 = done_cnt;
        for (int i = 47; i > 28; i--) strobe(r1[i], 2);
        reset = 1'b1; sample_en = 1'b1; cmd_in = r1[28];
        tick();
        reset = 1'b0; sample_en = 1'b0; cmd_in = 1'b1;
        chk_reset_vals("midrst");
        repeat (20) tick();
        chk("midrst_no_done", PW'(done_cnt), PW'(dc0));
        run_frame("r1_after_rst", r1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0);

        // Randomized frames with occasional corruption
        for (int n = 0; n < 24; n++) begin
            logic lng, skp;
            int len, kind, bit_pos;
            lng = 1'($urandom_range(0, 1));
            skp = ($urandom_range(0, 3) == 0);
            len = lng ? 136 : 48;
            f = '0;
            if (lng) begin
                for (int i = 8; i < 128; i++) f[i] = 1'($urandom_range(0, 1));
                f[133:128] = 6'h3F;
                f[7:1] = crc7_div(f, 127, 8);
            end else begin
                f[45:40] = 6'($urandom_range(0, 63));
                f[39:8]  = 32'($urandom);
                f[7:1]   = crc7_div(f, 47, 8);
            end
            f[0] = 1'b1;
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                bit_pos = $urandom_range(8, lng ? 127 : 45);
                f[bit_pos] = ~f[bit_pos];
            end else if (kind == 1) begin
                f[len-2] = 1'b1;
            end else if (kind == 2) begin
                f[0] = 1'b0;
            end
            run_frame($sformatf("rnd%0d", n), f, lng, skp, $urandom_range(1, 3),
                      $urandom_range(0, 10), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
